adc_ms_seq: RTL and testbench

- Parametrised multislope ADC conversion sequencer: the next generation of the existing single-configuration controller.
- Drives the integrator switches through reset, multi-period runup, settle and rundown phases, counts runup decisions and fast rundown clocks, and hands each result out on a valid/ready port (UART framing is moved to a separate block).
- New behaviour:
  - runtime-programmable runup length, period and minor-phase width;
  - rundown gate closes at the first comparator crossing;
  - rundown overflow flag;
  - single-shot or continuous mode;
  - result back-pressure.

---
 rtl/adc_ms_seq_if.sv | 40 ++++
 rtl/adc_ms_seq.sv | 330 +++++++++++++++++++++++++++++++++
 tb/tb_adc_ms_seq.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/adc_ms_seq_if.sv
// Signal bundle between the multislope sequencer (master) and its environment (slave):
// start/mode/comparator inputs, runtime configuration, switch controls and result stream.
interface adc_ms_seq_if #(
   parameter int unsigned CNT_W = 15,
   parameter int unsigned RD_W  = 16,
   parameter int unsigned PER_W = 8
);
   logic             start;
   logic             cont;
   logic             comp_n;
   logic [CNT_W-1:0] runup_set;
   logic [PER_W-1:0] period;
   logic [PER_W-1:0] minor;
   logic [RD_W-1:0]  rd_max;
   logic             sw_in;
   logic             sw_up;
   logic             sw_dn;
   logic             sw_rst;
   logic             sw_vref;
   logic             busy;
   logic             res_valid;
   logic             res_ready;
   logic [CNT_W-1:0] res_runup;
   logic [CNT_W-1:0] res_set;
   logic             res_sign;
   logic [RD_W-1:0]  res_rundown;
   logic             res_ovf;

   modport master (
      input  start, cont, comp_n, runup_set, period, minor, rd_max, res_ready,
      output sw_in, sw_up, sw_dn, sw_rst, sw_vref, busy,
      output res_valid, res_runup, res_set, res_sign, res_rundown, res_ovf
   );

   modport slave (
      output start, cont, comp_n, runup_set, period, minor, rd_max, res_ready,
      input  sw_in, sw_up, sw_dn, sw_rst, sw_vref, busy,
      input  res_valid, res_runup, res_set, res_sign, res_rundown, res_ovf
   );
endinterface

// File: rtl/adc_ms_seq.sv
// Multislope ADC conversion sequencer: integrator reset, multi-period runup, settle and
// gated rundown, with the result handed out on a valid/ready port.
module adc_ms_seq #(
   parameter int unsigned DIV          = 40,
   parameter int unsigned CNT_W        = 15,
   parameter int unsigned RD_W         = 16,
   parameter int unsigned PER_W        = 8,
   parameter int unsigned RST_TICKS    = 4000,
   parameter int unsigned SETTLE_TICKS = 20,
   parameter int unsigned RD_TICKS     = 1200
) (
   input logic          mclk,
   input logic          rst,
   adc_ms_seq_if.master bus
);

   localparam int unsigned DIV_W = $clog2(DIV);
   localparam int unsigned MAX_TICKS =
      (RST_TICKS > SETTLE_TICKS) ? ((RST_TICKS > RD_TICKS) ? RST_TICKS : RD_TICKS)
                                 : ((SETTLE_TICKS > RD_TICKS) ? SETTLE_TICKS : RD_TICKS);
   localparam int unsigned TW = $clog2(MAX_TICKS + 1);

   localparam logic [DIV_W-1:0] DivLast    = DIV_W'(DIV - 1);
   localparam logic [TW-1:0]    RstLast    = TW'(RST_TICKS - 1);
   localparam logic [TW-1:0]    SettleLast = TW'(SETTLE_TICKS - 1);
   localparam logic [TW-1:0]    RdLast     = TW'(RD_TICKS - 1);

   typedef enum logic [2:0] {StIdle, StRst, StRunup, StSettle, StRundown, StDone} state_e;

   state_e state_q, state_d;

   logic [DIV_W-1:0] div_q;
   logic             tick;
   logic [1:0]       start_sync_q, comp_n_sync_q;
   logic             start_s, start_prev_q, comp;
   logic             armed_q, armed_d;
   logic [TW-1:0]    st_cnt_q, st_cnt_d;
   logic             st_last;
   logic [PER_W-1:0] t_q, t_d;
   logic [CNT_W-1:0] pcnt_q, pcnt_d;
   logic [CNT_W-1:0] ru_q, ru_d;
   logic             rs_q, rs_d;
   logic             sign_q, sign_d;
   logic [CNT_W-1:0] set_sh_q, set_sh_d;
   logic [PER_W-1:0] per_sh_q, per_sh_d;
   logic [PER_W-1:0] minor_sh_q, minor_sh_d;
   logic [RD_W-1:0]  rd_cnt_q, rd_cnt_d;
   logic             gate_q, gate_d;
   logic             ovf_q, ovf_d;
   logic             res_valid_q, res_valid_d;
   logic [CNT_W-1:0] res_runup_q, res_runup_d;
   logic [CNT_W-1:0] res_set_q, res_set_d;
   logic             res_sign_q, res_sign_d;
   logic [RD_W-1:0]  res_rundown_q, res_rundown_d;
   logic             res_ovf_q, res_ovf_d;
   logic             t_last, leave_idle, done_load;
   logic [PER_W:0]   dn_lim;
   logic             ru_dn;
   logic             sw_in, sw_up, sw_dn, sw_rst, sw_vref;

   // Sequencer tick: one mclk pulse every DIV cycles.
   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         div_q <= '0;
      end else begin
         div_q <= tick ? '0 : div_q + 1'b1;
      end
   end

   assign tick = (div_q == DivLast);

   // Two-flop synchronisers for start and the comparator; comparator idles inactive.
   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         start_sync_q  <= 2'b00;
         comp_n_sync_q <= 2'b11;
         start_prev_q  <= 1'b0;
      end else begin
         start_sync_q  <= {start_sync_q[0], bus.start};
         comp_n_sync_q <= {comp_n_sync_q[0], bus.comp_n};
         start_prev_q  <= start_s;
      end
   end

   assign start_s = start_sync_q[1];
   assign comp    = ~comp_n_sync_q[1];

   assign st_last = ((state_q == StRst)     && (st_cnt_q == RstLast))    ||
                    ((state_q == StSettle)  && (st_cnt_q == SettleLast)) ||
                    ((state_q == StRundown) && (st_cnt_q == RdLast));
   assign t_last  = (t_q == per_sh_q);
   assign dn_lim  = {1'b0, per_sh_q} + {{PER_W{1'b0}}, 1'b1} - {1'b0, minor_sh_q};
   assign ru_dn   = rs_q ? (t_q < minor_sh_q) : ({1'b0, t_q} < dn_lim);

   // FSM state register.
   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: phases advance on ticks; DONE drains on the handshake at mclk rate.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (tick && start_s && (bus.cont || armed_q)) state_d = StRst;
         end
         StRst: begin
            if (tick) begin
               if (!start_s)     state_d = StIdle;
               else if (st_last) state_d = StRunup;
            end
         end
         StRunup: begin
            if (tick) begin
               if (!start_s)                          state_d = StIdle;
               else if (t_last && pcnt_q == set_sh_q) state_d = StSettle;
            end
         end
         StSettle: begin
            if (tick) begin
               if (!start_s)     state_d = StIdle;
               else if (st_last) state_d = StRundown;
            end
         end
         StRundown: begin
            if (tick) begin
               if (!start_s)     state_d = StIdle;
               else if (st_last) state_d = StDone;
            end
         end
         StDone: begin
            if (!res_valid_q || bus.res_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign leave_idle = (state_q == StIdle) && (state_d == StRst);
   assign done_load  = (state_q == StDone) && (!res_valid_q || bus.res_ready);

   // Datapath next state: shadows, phase/period counters, runup decisions, rundown gate.
   always_comb begin
      armed_d       = armed_q;
      st_cnt_d      = st_cnt_q;
      t_d           = t_q;
      pcnt_d        = pcnt_q;
      ru_d          = ru_q;
      rs_d          = rs_q;
      sign_d        = sign_q;
      set_sh_d      = set_sh_q;
      per_sh_d      = per_sh_q;
      minor_sh_d    = minor_sh_q;
      rd_cnt_d      = rd_cnt_q;
      gate_d        = gate_q;
      ovf_d         = ovf_q;
      res_valid_d   = res_valid_q;
      res_runup_d   = res_runup_q;
      res_set_d     = res_set_q;
      res_sign_d    = res_sign_q;
      res_rundown_d = res_rundown_q;
      res_ovf_d     = res_ovf_q;

      // A single-shot conversion needs a fresh start edge since the last one began.
      if (start_s && !start_prev_q) armed_d = 1'b1;
      if (leave_idle) begin
         armed_d    = 1'b0;
         st_cnt_d   = '0;
         set_sh_d   = bus.runup_set;
         per_sh_d   = bus.period;
         minor_sh_d = bus.minor;
      end

      if (tick) begin
         case (state_q)
            StRst: begin
               if (st_last) begin
                  st_cnt_d = '0;
                  t_d      = '0;
                  pcnt_d   = '0;
                  ru_d     = '0;
                  rs_d     = 1'b0;
               end else begin
                  st_cnt_d = st_cnt_q + 1'b1;
               end
            end
            StRunup: begin
               if (t_last) begin
                  t_d  = '0;
                  rs_d = comp;
                  // The final period steers the integrator but is not counted.
                  if (pcnt_q != set_sh_q) begin
                     ru_d   = ru_q + CNT_W'(comp);
                     pcnt_d = pcnt_q + 1'b1;
                  end
               end else begin
                  t_d = t_q + 1'b1;
               end
            end
            StSettle: begin
               if (st_last) begin
                  st_cnt_d = '0;
                  sign_d   = comp;
                  gate_d   = 1'b1;
                  rd_cnt_d = '0;
                  ovf_d    = 1'b0;
               end else begin
                  st_cnt_d = st_cnt_q + 1'b1;
               end
            end
            StRundown: st_cnt_d = st_cnt_q + 1'b1;
            default: ;
         endcase
      end

      // Rundown counts at mclk rate until the first crossing or the overflow limit.
      if (state_q == StRundown && gate_q) begin
         if (rd_cnt_q >= bus.rd_max) begin
            ovf_d  = 1'b1;
            gate_d = 1'b0;
         end else if (comp != sign_q) begin
            gate_d = 1'b0;
         end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
            if (rd_cnt_d == bus.rd_max) begin
               ovf_d  = 1'b1;
               gate_d = 1'b0;
            end
         end
      end

      if (res_valid_q && bus.res_ready) res_valid_d = 1'b0;
      if (done_load) begin
         res_valid_d   = 1'b1;
         res_runup_d   = ru_q;
         res_set_d     = set_sh_q;
         res_sign_d    = sign_q;
         res_rundown_d = rd_cnt_q;
         res_ovf_d     = ovf_q;
      end
   end

   // Datapath registers.
   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         armed_q       <= 1'b0;
         st_cnt_q      <= '0;
         t_q           <= '0;
         pcnt_q        <= '0;
         ru_q          <= '0;
         rs_q          <= 1'b0;
         sign_q        <= 1'b0;
         set_sh_q      <= '0;
         per_sh_q      <= '0;
         minor_sh_q    <= '0;
         rd_cnt_q      <= '0;
         gate_q        <= 1'b0;
         ovf_q         <= 1'b0;
         res_valid_q   <= 1'b0;
         res_runup_q   <= '0;
         res_set_q     <= '0;
         res_sign_q    <= 1'b0;
         res_rundown_q <= '0;
         res_ovf_q     <= 1'b0;
      end else begin
         armed_q       <= armed_d;
         st_cnt_q      <= st_cnt_d;
         t_q           <= t_d;
         pcnt_q        <= pcnt_d;
         ru_q          <= ru_d;
         rs_q          <= rs_d;
         sign_q        <= sign_d;
         set_sh_q      <= set_sh_d;
         per_sh_q      <= per_sh_d;
         minor_sh_q    <= minor_sh_d;
         rd_cnt_q      <= rd_cnt_d;
         gate_q        <= gate_d;
         ovf_q         <= ovf_d;
         res_valid_q   <= res_valid_d;
         res_runup_q   <= res_runup_d;
         res_set_q     <= res_set_d;
         res_sign_q    <= res_sign_d;
         res_rundown_q <= res_rundown_d;
         res_ovf_q     <= res_ovf_d;
      end
   end

   // FSM outputs: integrator switch configuration per phase.
   always_comb begin
      sw_in   = 1'b0;
      sw_up   = 1'b0;
      sw_dn   = 1'b0;
      sw_rst  = 1'b0;
      sw_vref = 1'b0;
      case (state_q)
         StRunup: begin
            sw_in   = 1'b1;
            sw_vref = 1'b1;
            sw_dn   = ru_dn;
            sw_up   = ~ru_dn;
         end
         StSettle: ;
         StRundown: begin
            sw_up = sign_q;
            sw_dn = ~sign_q;
         end
         default: begin
            sw_rst  = 1'b1;
            sw_vref = 1'b1;
         end
      endcase
   end

   assign bus.sw_in       = sw_in;
   assign bus.sw_up       = sw_up;
   assign bus.sw_dn       = sw_dn;
   assign bus.sw_rst      = sw_rst;
   assign bus.sw_vref     = sw_vref;
   assign bus.busy        = (state_q != StIdle);
   assign bus.res_valid   = res_valid_q;
   assign bus.res_runup   = res_runup_q;
   assign bus.res_set     = res_set_q;
   assign bus.res_sign    = res_sign_q;
   assign bus.res_rundown = res_rundown_q;
   assign bus.res_ovf     = res_ovf_q;

endmodule

// File: tb/tb_adc_ms_seq.sv
// Directed bench for adc_ms_seq with a short tick (DIV=4) and shortened phase lengths.
module tb_adc_ms_seq;

   localparam int unsigned DIV          = 4;
   localparam int unsigned CNT_W        = 15;
   localparam int unsigned RD_W         = 16;
   localparam int unsigned PER_W        = 8;
   localparam int unsigned RST_TICKS    = 5;
   localparam int unsigned SETTLE_TICKS = 3;
   localparam int unsigned RD_TICKS     = 100;

   logic mclk;
   logic rst;
   int   n_cmp;
   int   n_err;
   int   dn_cyc;
   int   up_cyc;
   logic mon_clr;

   adc_ms_seq_if #(.CNT_W(CNT_W), .RD_W(RD_W), .PER_W(PER_W)) bus ();

   adc_ms_seq #(
      .DIV          (DIV),
      .CNT_W        (CNT_W),
      .RD_W         (RD_W),
      .PER_W        (PER_W),
      .RST_TICKS    (RST_TICKS),
      .SETTLE_TICKS (SETTLE_TICKS),
      .RD_TICKS     (RD_TICKS)
   ) dut (
      .mclk (mclk),
      .rst  (rst),
      .bus  (bus)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   // Runup switch activity, in mclk cycles, since the last clear.
   always @(negedge mclk) begin
      if (mon_clr) begin
         dn_cyc <= 0;
         up_cyc <= 0;
      end else if (bus.sw_in) begin
         if (bus.sw_dn) dn_cyc <= dn_cyc + 1;
         if (bus.sw_up) up_cyc <= up_cyc + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp = n_cmp + 1;
      if (got !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic cond(input int sel);
      case (sel)
         0:       return bus.busy;
         1:       return bus.res_valid;
         2:       return bus.sw_in;
         3:       return !bus.sw_in && (bus.sw_up || bus.sw_dn);
         4:       return bus.busy && bus.sw_rst;
         default: return !bus.busy;
      endcase
   endfunction

   task automatic wait_for(input int sel, input int lim, input string tag);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         @(negedge mclk);
         if (cond(sel)) begin
            ok = 1'b1;
            break;
         end
      end
      chk(tag, 64'(ok), 64'd1);
   endtask

   task automatic clear_mon();
      mon_clr = 1'b1;
      repeat (2) @(negedge mclk);
      mon_clr = 1'b0;
   endtask

   task automatic consume();
      bus.res_ready = 1'b1;
      @(negedge mclk);
      bus.res_ready = 1'b0;
      chk("consumed_valid", 64'(bus.res_valid), 64'd0);
   endtask

   function automatic logic [4:0] sw_vec();
      return {bus.sw_in, bus.sw_up, bus.sw_dn, bus.sw_rst, bus.sw_vref};
   endfunction

   initial begin
      n_cmp         = 0;
      n_err         = 0;
      mon_clr       = 1'b1;
      rst           = 1'b0;
      bus.start     = 1'b0;
      bus.cont      = 1'b0;
      bus.comp_n    = 1'b1;
      bus.runup_set = 15'd3;
      bus.period    = 8'd9;
      bus.minor     = 8'd1;
      bus.rd_max    = 16'd1000;
      bus.res_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_sw", 64'(sw_vec()), 64'b00011);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_valid", 64'(bus.res_valid), 64'd0);
      chk("rst_res", 64'({bus.res_runup, bus.res_set, bus.res_rundown}), 64'd0);
      repeat (3) @(negedge mclk);
      rst = 1'b0;

      // Single shot, comp held 0; runup_set changed mid-conversion must not matter.
      clear_mon();
      bus.start = 1'b1;
      wait_for(0, 50, "t1_busy");
      bus.runup_set = 15'd7;
      wait_for(1, 2000, "t1_valid");
      chk("t1_runup", 64'(bus.res_runup), 64'd0);
      chk("t1_set", 64'(bus.res_set), 64'd3);
      chk("t1_sign", 64'(bus.res_sign), 64'd0);
      chk("t1_rundown", 64'(bus.res_rundown), 64'd400);
      chk("t1_ovf", 64'(bus.res_ovf), 64'd0);
      chk("t1_dn_cyc", 64'(dn_cyc), 64'd144);
      chk("t1_up_cyc", 64'(up_cyc), 64'd16);
      consume();
      repeat (300) @(negedge mclk);
      chk("t1_single_busy", 64'(bus.busy), 64'd0);
      chk("t1_single_valid", 64'(bus.res_valid), 64'd0);

      // comp=1 at every decision; rundown crossing after 157 mclk, then comp returns.
      bus.start     = 1'b0;
      bus.runup_set = 15'd3;
      bus.comp_n    = 1'b0;
      repeat (10) @(negedge mclk);
      clear_mon();
      bus.start = 1'b1;
      wait_for(3, 2000, "t2_rundown");
      repeat (155) @(negedge mclk);
      bus.comp_n = 1'b1;
      repeat (20) @(negedge mclk);
      bus.comp_n = 1'b0;
      wait_for(1, 1000, "t2_valid");
      chk("t2_runup", 64'(bus.res_runup), 64'd3);
      chk("t2_sign", 64'(bus.res_sign), 64'd1);
      chk("t2_rundown", 64'(bus.res_rundown), 64'd157);
      chk("t2_ovf", 64'(bus.res_ovf), 64'd0);
      chk("t2_dn_cyc", 64'(dn_cyc), 64'd48);
      chk("t2_up_cyc", 64'(up_cyc), 64'd112);
      consume();

      // Rundown never crosses: saturate at rd_max.
      bus.start  = 1'b0;
      bus.rd_max = 16'd100;
      repeat (10) @(negedge mclk);
      bus.start = 1'b1;
      wait_for(1, 2000, "t3_valid");
      chk("t3_rundown", 64'(bus.res_rundown), 64'd100);
      chk("t3_ovf", 64'(bus.res_ovf), 64'd1);
      chk("t3_runup", 64'(bus.res_runup), 64'd3);
      consume();

      // Continuous mode with back-pressure.
      bus.start     = 1'b0;
      bus.rd_max    = 16'd1000;
      bus.comp_n    = 1'b1;
      bus.cont      = 1'b1;
      bus.runup_set = 15'd2;
      repeat (10) @(negedge mclk);
      bus.start = 1'b1;
      wait_for(0, 50, "t4_busy");
      bus.runup_set = 15'd3;
      wait_for(1, 2000, "t4_valid1");
      chk("t4_set1", 64'(bus.res_set), 64'd2);
      wait_for(2, 2000, "t4_runup2");
      wait_for(4, 2000, "t4_done2");
      repeat (10) @(negedge mclk);
      chk("t4_held_valid", 64'(bus.res_valid), 64'd1);
      chk("t4_held_set", 64'(bus.res_set), 64'd2);
      chk("t4_held_busy", 64'(bus.busy), 64'd1);
      bus.res_ready = 1'b1;
      @(negedge mclk);
      bus.res_ready = 1'b0;
      chk("t4_valid2", 64'(bus.res_valid), 64'd1);
      chk("t4_set2", 64'(bus.res_set), 64'd3);
      chk("t4_rundown2", 64'(bus.res_rundown), 64'd400);
      bus.start = 1'b0;
      bus.cont  = 1'b0;
      wait_for(5, 50, "t4_idle");
      consume();

      // Abort mid-runup: back to idle, no result.
      repeat (10) @(negedge mclk);
      bus.start = 1'b1;
      wait_for(2, 200, "t5_runup");
      repeat (12) @(negedge mclk);
      bus.start = 1'b0;
      wait_for(5, 20, "t5_idle");
      chk("t5_sw", 64'(sw_vec()), 64'b00011);
      repeat (300) @(negedge mclk);
      chk("t5_no_valid", 64'(bus.res_valid), 64'd0);
      chk("t5_no_busy", 64'(bus.busy), 64'd0);

      // Async reset mid-rundown: outputs at reset values at once.
      bus.start = 1'b1;
      wait_for(3, 2000, "t6_rundown");
      repeat (10) @(negedge mclk);
      #2 rst = 1'b1;
      #1;
      chk("t6_sw", 64'(sw_vec()), 64'b00011);
      chk("t6_busy", 64'(bus.busy), 64'd0);
      chk("t6_valid", 64'(bus.res_valid), 64'd0);
      chk("t6_res_set", 64'(bus.res_set), 64'd0);
      chk("t6_res_rundown", 64'(bus.res_rundown), 64'd0);
      bus.start = 1'b0;
      repeat (3) @(negedge mclk);
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
